fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage and IF/ID pipeline register of the pipelined ARM-subset CPU. It is the producer side of the decode interface: it drives the registered instruction word `IR` and the condition-pass bit `Cond` consumed by the control-unit decoder. It maintains the PC, fetches from instruction memory with a req/ready handshake, and absorbs hazard-unit stalls with a one-entry skid buffer. It handles branch redirects from ID by flushing to the all-zero NOP word.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `imem_addr`  out  32  fetch address, always equal to the PC register.
- `imem_req`  out  1  fetch request; `imem_addr` is stable while high and no redirect occurs.
- `imem_ready`  in  1  memory returns `imem_data` for `imem_addr` in the same cycle.
- `imem_data`  in  32  instruction word.
- `stall`  in  1  hazard unit; hold the IF/ID contents.
- `branch_taken`  in  1  redirect request from ID.
- `branch_target`  in  32  redirect address, word aligned.
- `flags`  in  4  {N,Z,C,V} from the status register.
- `IR`  out  32  IF/ID instruction register to the decoder.
- `ID_PC`  out  32  address of `IR` plus 4.
- `ID_valid`  out  1  `IR` holds a fetched instruction, not a bubble.
- `Cond`  out  1  combinational condition-pass result for `IR`.

## Operation
- Registers: `PC`, `IR`, `ID_PC`, `ID_valid`, `skid_data`, `skid_pc`, and a 2-bit state.
- States:
  - BOOT: entered on reset; lasts 1 cycle; `imem_req`=0; always moves to RUN.
  - RUN: skid buffer empty; `imem_req`=1.
  - HELD: skid buffer full; `imem_req`=0.
- Priority: reset > `branch_taken` > `stall` > normal flow.
- `branch_taken`=1, in any state:
  - `PC`<=`branch_target`; `IR`<=0; `ID_valid`<=0; skid buffer discarded; next state RUN.
  - A same-cycle `imem_ready` response is dropped, and `PC` is not incremented from it.
- RUN with `imem_ready`=1 and `stall`=0: `IR`<=`imem_data`, `ID_PC`<=`PC`+4, `ID_valid`<=1, `PC`<=`PC`+4.
- RUN with `imem_ready`=1 and `stall`=1:
  - `skid_data`<=`imem_data`, `skid_pc`<=`PC`+4, `PC`<=`PC`+4.
  - IF/ID registers hold; next state HELD.
- RUN with `imem_ready`=0 and `stall`=0: insert a bubble (`IR`<=0, `ID_valid`<=0; `ID_PC` holds).
- RUN with `imem_ready`=0 and `stall`=1: everything holds.
- HELD with `stall`=1: hold.
- HELD with `stall`=0: `IR`<=`skid_data`, `ID_PC`<=`skid_pc`, `ID_valid`<=1; next state RUN. The next fetch is requested in the following cycle.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- `Cond` = `ID_valid` AND eval(`IR[31:28]`, `flags`), where eval is:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 is 0.

## Timing
- Reset values: `PC`=`RESET_PC`, `IR`=0, `ID_PC`=0, `ID_valid`=0, `Cond`=0, `imem_req`=0, state BOOT, skid buffer empty.
- `imem_addr`=`RESET_PC` during reset.
- `imem_req` first rises 1 cycle after `reset_n` is released.
- Fetch latency: a word accepted on edge k appears on `IR` after edge k; zero-wait memory sustains 1 instruction per cycle.
- Stall release from HELD delivers the buffered word on the release edge, costing 1 fetch cycle of bubble afterwards.
- Redirect: `branch_taken` sampled at edge k puts `IR`=0 after k; the target is requested in cycle k+1 and reaches `IR` after edge k+1 at the earliest.
- `reset_n` low mid-operation: all state returns to reset values on that edge. Any outstanding request is abandoned, and the memory tolerates the address change.
- `Cond` is purely combinational from the `IR`/`ID_valid` registers and `flags`; it has no registered delay.

## Test plan
- Reset and stream: `RESET_PC`=0, zero-wait memory returning addr+32'hE000_0000 → after BOOT, `IR` = E000_0000, E000_0004, … on consecutive edges; `ID_PC`=4, 8, …; `Cond`=1 (AL).
- Wait states: `imem_ready` low for 2 cycles at addr 8 → 2 bubbles (`IR`=0, `ID_valid`=0, `Cond`=0); `PC` holds at 8; then `IR` for addr 8 appears.
- Stall with skid: `stall`=1 for 3 cycles while ready → `IR` frozen; skid captures addr 12; `PC`=16; `imem_req`=0 for 2 cycles; on release `IR` = word@12, `ID_PC`=16.
- Branch beats stall: `branch_taken`=1 with `stall`=1 in HELD, target 32'h100 → `IR`=0, skid dropped; next fetch at 32'h100; word@100 arrives at `IR` 2 edges after the branch.
- Condition table: `IR[31:28]` swept 0–15 against `flags` 0000, 0100, 1001, 0010 → `Cond` matches the eval list (e.g. GT with N=1, V=0, Z=0 → 0; NV → 0).
- Mid-run reset and wrap: `PC`=FFFF_FFFC accepted → `PC`=0, `ID_PC`=0. Then `reset_n`=0 for 1 cycle mid-stall → all outputs return to reset values, state BOOT.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage and IF/ID pipeline register. Keeps the PC, fetches over a
// req/ready handshake, absorbs stalls with a one-entry skid buffer and evaluates Cond.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [3:0]  flags,
  output logic [31:0] IR,
  output logic [31:0] ID_PC,
  output logic        ID_valid,
  output logic        Cond
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] skid_data_q, skid_pc_q;
  logic        skid_load;
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc_q + 32'd4;
  assign imem_addr = pc_q;
  assign imem_req  = (state_q == ST_RUN);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    skid_load  = 1'b0;

    // A redirect wins over everything, including a response arriving in the same cycle.
    if (branch_taken) begin
      state_d    = ST_RUN;
      pc_d       = branch_target;
      ir_d       = '0;
      id_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (imem_ready) begin
            pc_d = pc_plus4;
            if (stall) begin
              skid_load = 1'b1;
              state_d   = ST_HELD;
            end else begin
              ir_d       = imem_data;
              id_pc_d    = pc_plus4;
              id_valid_d = 1'b1;
            end
          end else if (!stall) begin
            ir_d       = '0;
            id_valid_d = 1'b0;
          end
        end
        ST_HELD: begin
          if (!stall) begin
            ir_d       = skid_data_q;
            id_pc_d    = skid_pc_q;
            id_valid_d = 1'b1;
            state_d    = ST_RUN;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
  end

  // NOTE: skid storage has no reset; its contents are only read while the state says HELD.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_data_q <= imem_data;
      skid_pc_q   <= pc_plus4;
    end
  end

  logic flag_n, flag_z, flag_c, flag_v, cond_pass;
  assign {flag_n, flag_z, flag_c, flag_v} = flags;

  always_comb begin
    cond_pass = 1'b0;
    case (ir_q[31:28])
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = !flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = !flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = !flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = !flag_v;
      4'h8: cond_pass = flag_c && !flag_z;
      4'h9: cond_pass = !flag_c || flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = !flag_z && (flag_n == flag_v);
      4'hD: cond_pass = flag_z || (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign IR       = ir_q;
  assign ID_PC    = id_pc_q;
  assign ID_valid = id_valid_q;
  assign Cond     = id_valid_q && cond_pass;

endmodule
